// File: rtl/rtc_slave.sv
// Memory-mapped BCD real-time clock: prescaled seconds tick, hh:mm:ss time, uptime counter.
// Optional alarm compare/flag logic is built only when RTC_ALARM_EN is defined.
`timescale 1ns/1ps
module rtc_slave #(
    parameter int CLK_FREQ        = 50000000,
    parameter int SLAVEADDR_WIDTH = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       slave_rd,
    input  logic [SLAVEADDR_WIDTH-1:0] slave_raddr,
    output logic [31:0]                slave_rdata,
    input  logic                       slave_wr,
    input  logic [SLAVEADDR_WIDTH-1:0] slave_waddr,
    input  logic [31:0]                slave_wdata,
    output logic                       sec_pulse,
    output logic                       alarm_irq
);

    localparam int PW = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0] PTERM = PW'(CLK_FREQ - 1);

    localparam logic [1:0] A_TIME   = 2'd0;
    localparam logic [1:0] A_CTRL   = 2'd1;
    localparam logic [1:0] A_UPTIME = 2'd2;
    localparam logic [1:0] A_ALARM  = 2'd3;

    function automatic logic [7:0] bcd_fix(input logic [7:0] f, input logic [7:0] maxv);
        // Valid BCD digits compare correctly as plain hex against the BCD limit.
        if (f[7:4] > 4'd9 || f[3:0] > 4'd9 || f > maxv) return 8'h00;
        return f;
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] f);
        if (f[3:0] == 4'd9) return {f[7:4] + 4'd1, 4'd0};
        return {f[7:4], f[3:0] + 4'd1};
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    hh_q, mm_q, ss_q, hh_d, mm_d, ss_d;
    logic [7:0]    hh_nx, mm_nx, ss_nx;
    logic [31:0]   uptime_q, uptime_d;
    logic          run_q, run_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          pulse_q, pulse_d;
    logic          tick, tick_eff, time_wr, ctrl_wr;
    logic [31:0]   ctrl_rd, alarm_rd;

    assign time_wr  = slave_wr && (slave_waddr[3:2] == A_TIME);
    assign ctrl_wr  = slave_wr && (slave_waddr[3:2] == A_CTRL);
    assign tick     = run_q && (presc_q == PTERM);
    // A TIME write swallows a coincident tick entirely.
    assign tick_eff = tick && !time_wr;

    always_comb begin
        ss_nx = (ss_q == 8'h59) ? 8'h00 : bcd_inc(ss_q);
        mm_nx = mm_q;
        hh_nx = hh_q;
        if (ss_q == 8'h59) begin
            mm_nx = (mm_q == 8'h59) ? 8'h00 : bcd_inc(mm_q);
            if (mm_q == 8'h59) hh_nx = (hh_q == 8'h23) ? 8'h00 : bcd_inc(hh_q);
        end
    end

    always_comb begin
        presc_d  = presc_q;
        hh_d     = hh_q;
        mm_d     = mm_q;
        ss_d     = ss_q;
        uptime_d = uptime_q;
        run_d    = run_q;
        pulse_d  = tick_eff;
        if (run_q) presc_d = tick ? '0 : presc_q + PW'(1);
        if (time_wr) begin
            presc_d = '0;
            hh_d    = bcd_fix(slave_wdata[23:16], 8'h23);
            mm_d    = bcd_fix(slave_wdata[15:8],  8'h59);
            ss_d    = bcd_fix(slave_wdata[7:0],   8'h59);
        end else if (tick) begin
            hh_d     = hh_nx;
            mm_d     = mm_nx;
            ss_d     = ss_nx;
            uptime_d = uptime_q + 32'd1;
        end
        if (ctrl_wr) run_d = slave_wdata[0];
    end

`ifdef RTC_ALARM_EN
    logic [23:0] alarm_q, alarm_d;
    logic        alen_q, alen_d;
    logic        flag_q, flag_d;
    logic        match;

    assign match = tick_eff && alen_q && ({hh_nx, mm_nx, ss_nx} == alarm_q);

    always_comb begin
        alarm_d = alarm_q;
        alen_d  = alen_q;
        flag_d  = flag_q;
        if (slave_wr && (slave_waddr[3:2] == A_ALARM)) alarm_d = slave_wdata[23:0];
        if (ctrl_wr) begin
            alen_d = slave_wdata[1];
            if (slave_wdata[2]) flag_d = 1'b0;
        end
        if (match) flag_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_q <= '0;
            alen_q  <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
            alen_q  <= alen_d;
            flag_q  <= flag_d;
        end
    end

    assign ctrl_rd   = {29'd0, flag_q, alen_q, run_q};
    assign alarm_rd  = {8'h00, alarm_q};
    assign alarm_irq = flag_q & alen_q;
`else
    assign ctrl_rd   = {31'd0, run_q};
    assign alarm_rd  = 32'd0;
    assign alarm_irq = 1'b0;
`endif

    always_comb begin
        rdata_d = rdata_q;
        if (slave_rd) begin
            case (slave_raddr[3:2])
                A_TIME:   rdata_d = {8'h00, hh_q, mm_q, ss_q};
                A_CTRL:   rdata_d = ctrl_rd;
                A_UPTIME: rdata_d = uptime_q;
                default:  rdata_d = alarm_rd;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q  <= '0;
            hh_q     <= 8'h00;
            mm_q     <= 8'h00;
            ss_q     <= 8'h00;
            uptime_q <= '0;
            run_q    <= 1'b1;
            rdata_q  <= '0;
            pulse_q  <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            hh_q     <= hh_d;
            mm_q     <= mm_d;
            ss_q     <= ss_d;
            uptime_q <= uptime_d;
            run_q    <= run_d;
            rdata_q  <= rdata_d;
            pulse_q  <= pulse_d;
        end
    end

    assign slave_rdata = rdata_q;
    assign sec_pulse   = pulse_q;

    logic unused_bits;
    assign unused_bits = ^{slave_raddr[SLAVEADDR_WIDTH-1:4], slave_raddr[1:0],
                           slave_waddr[SLAVEADDR_WIDTH-1:4], slave_waddr[1:0],
                           slave_wdata[31:24]};

endmodule
